// File: rtl/serial2parallel_rx_if.sv
// Bundle of serial-in / FIFO-out signals for serial2parallel_rx.
// The slave modport is the receiver; the master modport is the serial source and word consumer.
interface serial2parallel_rx_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic                     din;
  logic                     valid_in;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     frame_err;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output din, valid_in, out_ready,
    input  out_data, out_valid, frame_err, overflow, level
  );

  modport slave (
    input  din, valid_in, out_ready,
    output out_data, out_valid, frame_err, overflow, level
  );
endinterface

// File: rtl/serial2parallel_rx.sv
// MSB-first serial deserializer feeding a DEPTH-word output FIFO.
// A frame starts on valid_in; frame_err and overflow are registered one-cycle pulses.
module serial2parallel_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial2parallel_rx_if.slave  bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [BW-1:0]    r_bcnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_frame_err;
  logic             r_overflow;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;

  logic [WIDTH-1:0] w_word;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_accept;

  // Shifting left places the first captured bit at WIDTH-1 once the frame completes.
  assign w_word   = {r_shift[WIDTH-2:0], bus.din};
  assign w_push   = (r_state == SHIFT) && !bus.valid_in && (r_bcnt == BW'(WIDTH - 1));
  assign w_pop    = (r_level != '0) && bus.out_ready;
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_accept = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.valid_in) begin
            r_shift <= w_word;
            r_bcnt  <= BW'(1);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift <= w_word;
          // A new frame marker mid-word abandons the partial word and restarts.
          if (bus.valid_in) begin
            r_frame_err <= 1'b1;
            r_bcnt      <= BW'(1);
          end else if (r_bcnt == BW'(WIDTH - 1)) begin
            r_bcnt  <= '0;
            r_state <= IDLE;
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_bcnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && !w_accept;
      if (w_accept) begin
        r_mem[r_wptr] <= w_word;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_accept && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_accept && w_pop) r_level <= r_level - LW'(1);
    end
  end

  assign bus.out_data  = r_mem[r_rptr];
  assign bus.out_valid = (r_level != '0);
  assign bus.level     = r_level;
  assign bus.frame_err = r_frame_err;
  assign bus.overflow  = r_overflow;
endmodule
